// File: rtl/pulse_train_decoder.sv
// ============================================================================
// Module   : pulse_train_decoder
// Purpose  : Samples an asynchronous pulse-train line once per tick, decodes
//            one complete train and reports the pulses in the first set, the
//            number of sets, and error flags for malformed trains.
// Revision : 1.0 - initial release
//
// Ports
//   CLOCK_50       in   system clock, all logic on posedge
//   s_reset        in   synchronous reset, active-high, overrides tick_en
//   tick_en        in   one-cycle sampling strobe at the generator step rate
//   pulse_in       in   asynchronous pulse line (2-flop synchronised here)
//   busy           out  high from first detected pulse until train finalised
//   frame_valid    out  one-cycle strobe when new results are latched
//   pulses_per_set out  pulse count of the first set of the last train
//   num_sets       out  set count of the last train
//   err            out  [0] width error, [1] set mismatch, [2] counter overflow
//
// Build option
//   PULSE_WIDTH_CHECK_EN : when defined, a high run longer than one tick flags
//                          err[0]. When undefined, any high run counts as a
//                          single pulse and err[0] is tied to 0.
// ============================================================================
`default_nettype none

module pulse_train_decoder #(
  parameter int CNT_W       = 4,
  parameter int SET_GAP_MIN = 2,
  parameter int END_GAP     = 4
) (
  input  logic             CLOCK_50,
  input  logic             s_reset,
  input  logic             tick_en,
  input  logic             pulse_in,
  output logic             busy,
  output logic             frame_valid,
  output logic [CNT_W-1:0] pulses_per_set,
  output logic [CNT_W-1:0] num_sets,
  output logic [2:0]       err
);

`ifdef PULSE_WIDTH_CHECK_EN
  localparam bit WIDTH_CHECK = 1'b1;
`else
  localparam bit WIDTH_CHECK = 1'b0;
`endif

  localparam int LR_W = $clog2(END_GAP + 1);
  localparam logic [LR_W-1:0]  END_GAP_L = LR_W'(END_GAP);
  localparam logic [LR_W-1:0]  SET_GAP_L = LR_W'(SET_GAP_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             sync1, sync2;
  logic [CNT_W-1:0] pulse_cnt, set_cnt, ref_cnt;
  logic             ref_set;
  logic [LR_W-1:0]  low_run;
  logic [2:0]       err_acc;

  logic             sample;
  logic [LR_W-1:0]  low_run_inc;
  logic [CNT_W-1:0] pulse_inc, set_inc;
  logic [2:0]       close_err;
  logic [2:0]       final_err;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge CLOCK_50) begin
    if (s_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;

  // Saturating increments and the error contribution of closing a set.
  always_comb begin
    low_run_inc = (low_run == END_GAP_L) ? low_run : low_run + 1'b1;
    pulse_inc   = (pulse_cnt == CNT_MAX) ? pulse_cnt : pulse_cnt + 1'b1;
    set_inc     = (set_cnt == CNT_MAX) ? set_cnt : set_cnt + 1'b1;
    close_err   = {(set_cnt == CNT_MAX), (ref_set && (pulse_cnt != ref_cnt)), 1'b0};
    final_err   = err_acc | close_err;
    if (!WIDTH_CHECK) final_err[0] = 1'b0;
  end

  // FSM: state register.
  always_ff @(posedge CLOCK_50) begin
    if (s_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM: next-state logic; moves only on tick_en cycles.
  always_comb begin
    state_nxt = state;
    if (tick_en) begin
      case (state)
        S_IDLE: if (sample) state_nxt = S_HIGH;
        S_HIGH: if (!sample) state_nxt = S_LOW;
        S_LOW: begin
          if (sample)                          state_nxt = S_HIGH;
          else if (low_run_inc == END_GAP_L)   state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Counters, error accumulation and result registers.
  always_ff @(posedge CLOCK_50) begin
    if (s_reset) begin
      pulse_cnt      <= '0;
      set_cnt        <= '0;
      ref_cnt        <= '0;
      ref_set        <= 1'b0;
      low_run        <= '0;
      err_acc        <= '0;
      frame_valid    <= 1'b0;
      pulses_per_set <= '0;
      num_sets       <= '0;
      err            <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (tick_en) begin
        case (state)
          S_IDLE: begin
            if (sample) begin
              pulse_cnt <= CNT_ONE;
              set_cnt   <= '0;
              ref_cnt   <= '0;
              ref_set   <= 1'b0;
              low_run   <= '0;
              err_acc   <= '0;
            end
          end
          S_HIGH: begin
            if (!sample)          low_run    <= LR_W'(1);
            else if (WIDTH_CHECK) err_acc[0] <= 1'b1;
          end
          S_LOW: begin
            if (!sample) begin
              low_run <= low_run_inc;
              if (low_run_inc == END_GAP_L) begin
                // Finalise: results include the closing of the last set.
                pulses_per_set <= ref_set ? ref_cnt : pulse_cnt;
                num_sets       <= set_inc;
                err            <= final_err;
                frame_valid    <= 1'b1;
              end
            end else if (low_run < SET_GAP_L) begin
              pulse_cnt <= pulse_inc;
              if (pulse_cnt == CNT_MAX) err_acc[2] <= 1'b1;
            end else begin
              // Gap long enough to close the set; this pulse opens the next.
              if (!ref_set) begin
                ref_cnt <= pulse_cnt;
                ref_set <= 1'b1;
              end
              set_cnt   <= set_inc;
              err_acc   <= err_acc | close_err;
              pulse_cnt <= CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_decoder.sv
// ============================================================================
// Module   : tb_pulse_train_decoder
// Purpose  : Directed self-checking bench for pulse_train_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       s_reset  = 1'b1;
  logic       tick_en  = 1'b0;
  logic       pulse_in = 1'b0;
  logic       busy;
  logic       frame_valid;
  logic [3:0] pulses_per_set;
  logic [3:0] num_sets;
  logic [2:0] err;

  int checks   = 0;
  int failures = 0;
  int fv_count = 0;
  int fv_base;

  pulse_train_decoder dut (
    .CLOCK_50      (CLOCK_50),
    .s_reset       (s_reset),
    .tick_en       (tick_en),
    .pulse_in      (pulse_in),
    .busy          (busy),
    .frame_valid   (frame_valid),
    .pulses_per_set(pulses_per_set),
    .num_sets      (num_sets),
    .err           (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Count cycles in which frame_valid is high.
  always @(negedge CLOCK_50) if (frame_valid) fv_count++;

  // One generator step: set the line, let it cross the synchroniser, strobe.
  task automatic tick(input logic v);
    @(negedge CLOCK_50);
    pulse_in = v;
    repeat (3) @(negedge CLOCK_50);
    tick_en = 1'b1;
    @(negedge CLOCK_50);
    tick_en = 1'b0;
  endtask

  // Send n ticks, MSB of the used range first.
  task automatic send(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(bits[i]);
  endtask

  task automatic settle();
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    s_reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if ({pulses_per_set, num_sets, err} !== 11'd0) begin failures++;
      $display("FAIL reset_outs got=%0d/%0d/%b exp=0/0/000", pulses_per_set, num_sets, err); end
    s_reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_two_sets_of_three();
    fv_base = fv_count;
    send(64'b1010100010101, 13);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_mid got=%b exp=1", busy); end
    send(64'b0000, 4);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL t1_fv_cycles got=%0d exp=1", fv_count - fv_base); end
    checks++; if (pulses_per_set !== 4'd3) begin failures++; $display("FAIL t1_pps got=%0d exp=3", pulses_per_set); end
    checks++; if (num_sets !== 4'd2) begin failures++; $display("FAIL t1_sets got=%0d exp=2", num_sets); end
    checks++; if (err !== 3'b000) begin failures++; $display("FAIL t1_err got=%b exp=000", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after got=%b exp=0", busy); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL t1_fv_clear got=%b exp=0", frame_valid); end
  endtask

  task automatic test_single_pulse();
    fv_base = fv_count;
    send(64'b10000, 5);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL single_fv got=%0d exp=1", fv_count - fv_base); end
    checks++; if ({pulses_per_set, num_sets, err} !== {4'd1, 4'd1, 3'b000}) begin failures++;
      $display("FAIL single_outs got=%0d/%0d/%b exp=1/1/000", pulses_per_set, num_sets, err); end
  endtask

  task automatic test_set_mismatch();
    fv_base = fv_count;
    send(64'b101000101010000, 15);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL mismatch_fv got=%0d exp=1", fv_count - fv_base); end
    checks++; if (pulses_per_set !== 4'd2) begin failures++; $display("FAIL mismatch_pps got=%0d exp=2", pulses_per_set); end
    checks++; if (num_sets !== 4'd2) begin failures++; $display("FAIL mismatch_sets got=%0d exp=2", num_sets); end
    checks++; if (err !== 3'b010) begin failures++; $display("FAIL mismatch_err got=%b exp=010", err); end
  endtask

  task automatic test_width();
    logic [2:0] exp_err;
`ifdef PULSE_WIDTH_CHECK_EN
    exp_err = 3'b001;
`else
    exp_err = 3'b000;
`endif
    fv_base = fv_count;
    send(64'b110000, 6);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL width_fv got=%0d exp=1", fv_count - fv_base); end
    checks++; if (err !== exp_err) begin failures++; $display("FAIL width_err got=%b exp=%b", err, exp_err); end
    checks++; if ({pulses_per_set, num_sets} !== {4'd1, 4'd1}) begin failures++;
      $display("FAIL width_counts got=%0d/%0d exp=1/1", pulses_per_set, num_sets); end
  endtask

  task automatic test_reset_mid_train();
    fv_base = fv_count;
    send(64'b101, 3);
    // Reset coincides with a tick strobe.
    @(negedge CLOCK_50);
    pulse_in = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    s_reset = 1'b1;
    tick_en = 1'b1;
    @(negedge CLOCK_50);
    s_reset = 1'b0;
    tick_en = 1'b0;
    checks++; if ({busy, pulses_per_set, num_sets, err} !== 12'd0) begin failures++;
      $display("FAIL midreset_outs got=%b/%0d/%0d/%b exp=0/0/0/000", busy, pulses_per_set, num_sets, err); end
    send(64'b0000, 4);
    settle();
    checks++; if (fv_count - fv_base !== 0) begin failures++; $display("FAIL midreset_fv got=%0d exp=0", fv_count - fv_base); end
    send(64'b10000, 5);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL midreset_next_fv got=%0d exp=1", fv_count - fv_base); end
    checks++; if ({pulses_per_set, num_sets, err} !== {4'd1, 4'd1, 3'b000}) begin failures++;
      $display("FAIL midreset_next got=%0d/%0d/%b exp=1/1/000", pulses_per_set, num_sets, err); end
  endtask

  task automatic test_overflow();
    fv_base = fv_count;
    for (int p = 0; p < 16; p++) begin
      tick(1'b1);
      if (p != 15) tick(1'b0);
    end
    send(64'b0000, 4);
    settle();
    checks++; if (fv_count - fv_base !== 1) begin failures++; $display("FAIL ovf_fv got=%0d exp=1", fv_count - fv_base); end
    checks++; if (pulses_per_set !== 4'd15) begin failures++; $display("FAIL ovf_pps got=%0d exp=15", pulses_per_set); end
    checks++; if (num_sets !== 4'd1) begin failures++; $display("FAIL ovf_sets got=%0d exp=1", num_sets); end
    checks++; if (err !== 3'b100) begin failures++; $display("FAIL ovf_err got=%b exp=100", err); end
  endtask

  task automatic test_back_to_back();
    fv_base = fv_count;
    // Second train's first pulse arrives right after the END_GAP tick.
    send(64'b10000101010000, 14);
    settle();
    checks++; if (fv_count - fv_base !== 2) begin failures++; $display("FAIL b2b_fv got=%0d exp=2", fv_count - fv_base); end
    checks++; if ({pulses_per_set, num_sets, err} !== {4'd3, 4'd1, 3'b000}) begin failures++;
      $display("FAIL b2b_outs got=%0d/%0d/%b exp=3/1/000", pulses_per_set, num_sets, err); end
  endtask

  initial begin
    test_reset();
    test_two_sets_of_three();
    test_single_pulse();
    test_set_mismatch();
    test_width();
    test_reset_mid_train();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
